// File: rtl/fib_pkg.sv
// Shared constants and FSM state type for the Fibonacci
// generator and its downstream sequence checker.
package fib_pkg;

  localparam int FIB_WIDTH = 4;
  localparam int FIB_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAULT = 2'd3
  } fib_state_e;

endpackage

// File: rtl/fib_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at
// all-ones instead of wrapping to zero.
module fib_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/fib_seq_checker.sv
// Checks a Fibonacci term stream against the truncated recurrence.
// Define FIB_CAPTURE_EN to latch the first mismatch's exp/actual.
module fib_seq_checker
  import fib_pkg::*;
#(
  parameter int WIDTH       = FIB_WIDTH,
  parameter int CNT_W       = FIB_CNT_W,
  parameter int CHECK_SEED  = 1,
  parameter int SEED        = 1,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             fn_valid,
  input  logic [WIDTH:0]   fn_in,
  output logic             match_o,
  output logic             mismatch_o,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] term_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [1:0]       state_o,
  output logic [WIDTH:0]   cap_expected,
  output logic [WIDTH:0]   cap_actual
);

  localparam logic [WIDTH:0] SEED_V = (WIDTH+1)'(SEED);

  fib_state_e       r_state;
  logic [WIDTH-1:0] r_p1;
  logic [WIDTH-1:0] r_p2;
  logic             r_match;
  logic             r_mis;
  logic             r_sticky;

  logic             w_accept;
  logic             w_match;
  logic             w_mis;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_exp;

  assign w_sum    = {1'b0, r_p1} + {1'b0, r_p2};
  assign w_exp    = (r_state == ST_IDLE) ? SEED_V : w_sum;
  assign w_accept = fn_valid && !clr && (r_state != ST_FAULT);

  always_comb begin
    w_match = 1'b0;
    w_mis   = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        ST_IDLE: begin
          w_mis = (CHECK_SEED != 0) && (fn_in != SEED_V);
        end
        ST_CHECK: begin
          w_match = (fn_in == w_sum);
          w_mis   = (fn_in != w_sum);
        end
        default: ;
      endcase
    end
  end

  // History shifts with the actual sample so a corrupt term ages out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_p1     <= '0;
      r_p2     <= '0;
      r_match  <= 1'b0;
      r_mis    <= 1'b0;
      r_sticky <= 1'b0;
    end else if (clr) begin
      r_state  <= ST_IDLE;
      r_p1     <= '0;
      r_p2     <= '0;
      r_match  <= 1'b0;
      r_mis    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_match <= w_match;
      r_mis   <= w_mis;
      if (w_mis) r_sticky <= 1'b1;
      if (w_accept) begin
        unique case (r_state)
          ST_IDLE: begin
            r_p1    <= fn_in[WIDTH-1:0];
            r_state <= ST_PRIME;
          end
          ST_PRIME: begin
            r_p2    <= r_p1;
            r_p1    <= fn_in[WIDTH-1:0];
            r_state <= ST_CHECK;
          end
          ST_CHECK: begin
            r_p2 <= r_p1;
            r_p1 <= fn_in[WIDTH-1:0];
            if (w_mis && (STOP_ON_ERR != 0)) r_state <= ST_FAULT;
          end
          default: ;
        endcase
      end
    end
  end

  fib_sat_counter #(.CNT_W(CNT_W)) u_term (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (w_accept),
    .q     (term_count)
  );

  fib_sat_counter #(.CNT_W(CNT_W)) u_err (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (w_mis),
    .q     (err_count)
  );

  fib_sat_counter #(.CNT_W(CNT_W)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (w_accept && fn_in[WIDTH]),
    .q     (wrap_count)
  );

`ifdef FIB_CAPTURE_EN
  logic [WIDTH:0] r_cap_exp;
  logic [WIDTH:0] r_cap_act;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap_exp <= '0;
      r_cap_act <= '0;
    end else if (clr) begin
      r_cap_exp <= '0;
      r_cap_act <= '0;
    end else if (w_mis && !r_sticky) begin
      r_cap_exp <= w_exp;
      r_cap_act <= fn_in;
    end
  end

  assign cap_expected = r_cap_exp;
  assign cap_actual   = r_cap_act;
`else
  assign cap_expected = '0;
  assign cap_actual   = '0;
`endif

  assign match_o    = r_match;
  assign mismatch_o = r_mis;
  assign err_sticky = r_sticky;
  assign state_o    = r_state;

endmodule

// File: tb/tb_fib_seq_checker.sv
// Directed bench for fib_seq_checker: default, stop-on-error
// and narrow-counter instances share one stimulus stream.
module tb_fib_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       fn_valid = 1'b0;
  logic [4:0] fn_in = '0;

  logic       m_match, m_mis, m_stk;
  logic [7:0] m_err, m_term, m_wrap;
  logic [1:0] m_st;
  logic [4:0] m_cexp, m_cact;

  logic       s_match, s_mis, s_stk;
  logic [7:0] s_err, s_term, s_wrap;
  logic [1:0] s_st;
  logic [4:0] s_cexp, s_cact;

  logic       n_match, n_mis, n_stk;
  logic [1:0] n_err, n_term, n_wrap;
  logic [1:0] n_st;
  logic [4:0] n_cexp, n_cact;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;

  always #5 clk = ~clk;

  fib_seq_checker u_main (
    .clk(clk), .reset(reset), .clr(clr),
    .fn_valid(fn_valid), .fn_in(fn_in),
    .match_o(m_match), .mismatch_o(m_mis), .err_sticky(m_stk),
    .err_count(m_err), .term_count(m_term), .wrap_count(m_wrap),
    .state_o(m_st), .cap_expected(m_cexp), .cap_actual(m_cact)
  );

  fib_seq_checker #(.STOP_ON_ERR(1)) u_stop (
    .clk(clk), .reset(reset), .clr(clr),
    .fn_valid(fn_valid), .fn_in(fn_in),
    .match_o(s_match), .mismatch_o(s_mis), .err_sticky(s_stk),
    .err_count(s_err), .term_count(s_term), .wrap_count(s_wrap),
    .state_o(s_st), .cap_expected(s_cexp), .cap_actual(s_cact)
  );

  fib_seq_checker #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .clr(clr),
    .fn_valid(fn_valid), .fn_in(fn_in),
    .match_o(n_match), .mismatch_o(n_mis), .err_sticky(n_stk),
    .err_count(n_err), .term_count(n_term), .wrap_count(n_wrap),
    .state_o(n_st), .cap_expected(n_cexp), .cap_actual(n_cact)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] v);
    fn_valid = 1'b1;
    fn_in    = v;
    @(posedge clk);
    #1;
    fn_valid = 1'b0;
    pulses   = pulses + int'(m_match);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] clean [12];
    logic [4:0] bad   [12];
    clean = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd8, 5'd13,
              5'd21, 5'd18, 5'd7, 5'd9, 5'd16, 5'd9};
    bad   = clean;
    bad[4] = 5'd9;

    #12;
    check("rst_match", m_match, 0);
    check("rst_term", m_term, 0);
    check("rst_state", m_st, 0);
    check("rst_sticky", m_stk, 0);
    reset = 1'b1;

    // clean stream
    pulses = 0;
    for (int i = 0; i < 12; i++) send(clean[i]);
    check("t1_pulses", pulses, 10);
    check("t1_err", m_err, 0);
    check("t1_term", m_term, 12);
    check("t1_wrap", m_wrap, 3);
    check("t1_stk", m_stk, 0);
    check("t1_state", m_st, 2);
    check("t5_sat_term", n_term, 3);
    check("t5_sat_wrap", n_wrap, 3);
    check("t1_stop_term", s_term, 12);
    @(posedge clk);
    #1;
    check("idle_match", m_match, 0);
    check("idle_term", m_term, 12);
    do_clr();
    check("clr_term", m_term, 0);
    check("clr_state", m_st, 0);
    check("clr_wrap", m_wrap, 0);

    // corrupt term 8 -> 9
    for (int i = 0; i < 4; i++) send(bad[i]);
    check("t2_m3_match", m_match, 1);
    send(bad[4]);
    check("t2_mis9", m_mis, 1);
    check("t2_stop_state", s_st, 3);
    send(bad[5]);
    check("t2_mis13", m_mis, 1);
    send(bad[6]);
    check("t2_mis21", m_mis, 1);
    send(bad[7]);
    check("t2_match18", m_match, 1);
    check("t2_nomis18", m_mis, 0);
    for (int i = 8; i < 12; i++) send(bad[i]);
    check("t2_err", m_err, 3);
    check("t2_stk", m_stk, 1);
    check("t2_term", m_term, 12);
    check("t2_stop_term", s_term, 5);
    check("t2_stop_err", s_err, 1);
`ifdef FIB_CAPTURE_EN
    check("t2_cap_exp", m_cexp, 8);
    check("t2_cap_act", m_cact, 9);
`else
    check("t2_cap_exp", m_cexp, 0);
    check("t2_cap_act", m_cact, 0);
`endif
    do_clr();
    check("clr2_stk", m_stk, 0);
    check("clr2_err", m_err, 0);

    // bad seed
    send(5'd2);
    check("t3_mis", m_mis, 1);
    check("t3_state", m_st, 1);
    check("t3_err", m_err, 1);
`ifdef FIB_CAPTURE_EN
    check("t3_cap_exp", m_cexp, 1);
    check("t3_cap_act", m_cact, 2);
`else
    check("t3_cap_exp", m_cexp, 0);
    check("t3_cap_act", m_cact, 2'd0);
`endif
    do_clr();

    // stop on error
    send(5'd1);
    send(5'd2);
    send(5'd4);
    check("t4_mis", s_mis, 1);
    check("t4_state", s_st, 3);
    send(5'd5);
    check("t4_frozen_mis", s_mis, 0);
    send(5'd9);
    check("t4_term", s_term, 3);
    check("t4_err", s_err, 1);
    check("t4_state2", s_st, 3);
    do_clr();
    check("t4_clr_state", s_st, 0);
    check("t4_clr_term", s_term, 0);
    check("t4_clr_err", s_err, 0);
    check("t4_clr_stk", s_stk, 0);

    // async reset mid-stream
    for (int i = 0; i < 5; i++) send(clean[i]);
    check("t6_pre_match", m_match, 1);
    check("t6_pre_term", m_term, 5);
    #3;
    reset = 1'b0;
    #1;
    check("t6_rst_match", m_match, 0);
    check("t6_rst_term", m_term, 0);
    check("t6_rst_state", m_st, 0);
    #2;
    reset = 1'b1;
    send(5'd1);
    check("t6_seed_mis", m_mis, 0);
    check("t6_seed_term", m_term, 1);
    check("t6_seed_state", m_st, 1);

    // clr wins over a same-cycle sample
    fn_valid = 1'b1;
    fn_in    = 5'd2;
    clr      = 1'b1;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    fn_valid = 1'b0;
    check("t6_drop_term", m_term, 0);
    check("t6_drop_state", m_st, 0);
    send(5'd1);
    check("t6_after_term", m_term, 1);
    check("t6_after_mis", m_mis, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
